// File: rtl/mem_pkg.sv
// mem_pkg: shared state/owner types and the all-ones byte-enable constant for the memory port arbiter.
package mem_pkg;
    typedef enum logic [1:0] {ARB_IDLE, ARB_BUSY, ARB_RESP} arb_state_t;
    typedef enum logic {OWN_F, OWN_D} arb_owner_t;
    localparam logic [127:0] BE_ALL = '1;
endpackage

// File: rtl/arb_sat_counter.sv
// arb_sat_counter: clearable up-counter that saturates at a run-time limit.
//   clk, rst    clock, synchronous active-high reset
//   clk_en      advance enable; count holds while low
//   inc, clr    increment request, clear (clear wins)
//   limit       saturation value
//   count       current value
//   at_limit    count == limit
module arb_sat_counter #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clk_en,
    input  logic         inc,
    input  logic         clr,
    input  logic [W-1:0] limit,
    output logic [W-1:0] count,
    output logic         at_limit
);
    assign at_limit = count == limit;
    always_ff @(posedge clk)
        if (rst) count <= '0;
        else if (clk_en) count <= clr ? '0 : (inc && !at_limit) ? count + 1'b1 : count;
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between fetch (F) and data (D) with data priority and fetch anti-starvation.
//   clk, rst, clk_en                         clock, synchronous active-high reset, global advance enable
//   f_req/f_addr -> f_ack/f_rdata            fetch requester
//   d_req/d_we/d_be/d_addr/d_wdata -> d_ack/d_rdata   data requester
//   mem_req/mem_we/mem_be/mem_addr/mem_wdata, mem_ready/mem_rdata   memory side
//   err                                      timeout pulse (MEM_TIMEOUT_EN builds only, else 0)
// Optional feature macro: MEM_TIMEOUT_EN adds a BUSY timeout that completes the access with rdata 0 and err.
module mem_port_arbiter
    import mem_pkg::*;
#(
    parameter int AW           = 32,
    parameter int DW           = 32,
    parameter int STARVE_LIMIT = 4,
    parameter int TIMEOUT      = 255
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            clk_en,
    input  logic            f_req,
    input  logic [AW-1:0]   f_addr,
    output logic            f_ack,
    output logic [DW-1:0]   f_rdata,
    input  logic            d_req,
    input  logic            d_we,
    input  logic [DW/8-1:0] d_be,
    input  logic [AW-1:0]   d_addr,
    input  logic [DW-1:0]   d_wdata,
    output logic            d_ack,
    output logic [DW-1:0]   d_rdata,
    output logic            mem_req,
    output logic            mem_we,
    output logic [DW/8-1:0] mem_be,
    output logic [AW-1:0]   mem_addr,
    output logic [DW-1:0]   mem_wdata,
    input  logic            mem_ready,
    input  logic [DW-1:0]   mem_rdata,
    output logic            err
);
    localparam int SW = $clog2(STARVE_LIMIT + 1);
    arb_state_t    state, state_n;
    arb_owner_t    owner;
    logic          we_r;
    logic          grant_d, grant_f, done, timeout;
    logic          starve_inc, starve_clr, starve_at;
    logic [SW-1:0] starve_cnt;

    // F wins only once D has been granted STARVE_LIMIT times in a row over a waiting F.
    assign grant_d    = state == ARB_IDLE && d_req && !(f_req && starve_cnt == SW'(STARVE_LIMIT));
    assign grant_f    = state == ARB_IDLE && !grant_d && f_req;
    assign done       = state == ARB_BUSY && (mem_ready || timeout);
    assign starve_inc = grant_d && f_req && !starve_at;
    assign starve_clr = grant_f || (state == ARB_IDLE && !f_req);

    arb_sat_counter #(.W(SW)) u_starve (
        .clk(clk), .rst(rst), .clk_en(clk_en), .inc(starve_inc), .clr(starve_clr),
        .limit(SW'(STARVE_LIMIT)), .count(starve_cnt), .at_limit(starve_at)
    );

`ifdef MEM_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] tmr_cnt;
    logic          tmr_at, to_r;
    arb_sat_counter #(.W(TW)) u_timer (
        .clk(clk), .rst(rst), .clk_en(clk_en), .inc(state == ARB_BUSY && !tmr_at), .clr(state != ARB_BUSY),
        .limit(TW'(TIMEOUT)), .count(tmr_cnt), .at_limit(tmr_at)
    );
    assign timeout = state == ARB_BUSY && !mem_ready && tmr_cnt == TW'(TIMEOUT);
    always_ff @(posedge clk)
        if (rst) to_r <= 1'b0;
        else if (clk_en && done) to_r <= timeout;
    assign err = state == ARB_RESP && to_r;
`else
    assign timeout = 1'b0;
    assign err     = 1'b0;
`endif

    always_ff @(posedge clk)
        if (rst) state <= ARB_IDLE;
        else if (clk_en) state <= state_n;

    always_comb begin
        state_n = state;
        f_ack   = 1'b0;
        d_ack   = 1'b0;
        state_n = (grant_d || grant_f) ? ARB_BUSY : done ? ARB_RESP : (state == ARB_RESP) ? ARB_IDLE : state;
        f_ack   = state == ARB_RESP && owner == OWN_F;
        d_ack   = state == ARB_RESP && owner == OWN_D;
        mem_req = state == ARB_BUSY;
        mem_we  = state == ARB_BUSY && we_r;
    end

    always_ff @(posedge clk)
        if (rst) begin
            owner     <= OWN_F;
            we_r      <= 1'b0;
            mem_be    <= '0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            f_rdata   <= '0;
            d_rdata   <= '0;
        end else if (clk_en) begin
            if (grant_d || grant_f) begin
                owner     <= grant_d ? OWN_D : OWN_F;
                we_r      <= grant_d && d_we;
                mem_be    <= grant_d && d_we ? d_be : BE_ALL[DW/8-1:0];
                mem_addr  <= grant_d ? d_addr : f_addr;
                mem_wdata <= grant_d ? d_wdata : '0;
            end
            if (done && owner == OWN_F) f_rdata <= timeout ? '0 : mem_rdata;
            if (done && owner == OWN_D) d_rdata <= timeout ? '0 : mem_rdata;
        end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: table vectors plus corner sequences, scoreboarded against a latency-programmable memory model.
module tb_mem_port_arbiter;
    logic        clk = 1'b0;
    logic        rst = 1'b1, clk_en = 1'b1;
    logic        f_req = 1'b0, d_req = 1'b0, d_we = 1'b0;
    logic [31:0] f_addr = '0, d_addr = '0, d_wdata = '0;
    logic [3:0]  d_be = '0;
    logic        f_ack, d_ack, mem_req, mem_we, err;
    logic [31:0] f_rdata, d_rdata, mem_addr, mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_ready = 1'b0;
    logic [31:0] mem_rdata = '0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.AW(32), .DW(32), .STARVE_LIMIT(4), .TIMEOUT(8)) dut (
        .clk(clk), .rst(rst), .clk_en(clk_en),
        .f_req(f_req), .f_addr(f_addr), .f_ack(f_ack), .f_rdata(f_rdata),
        .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ack(d_ack), .d_rdata(d_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_ready(mem_ready), .mem_rdata(mem_rdata), .err(err)
    );

    typedef struct {
        logic        is_d;
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        tmo;
    } txn_t;

    typedef struct {
        logic        f_on, d_on, d_we, d_first;
        logic [3:0]  d_be, exp_be;
        logic [31:0] f_addr, d_addr, d_wdata, f_rd, d_rd;
        int          lat;
    } vec_t;

    txn_t        exp_q[$], f_q[$], d_q[$];
    int          checks = 0, failures = 0, lat = 1, mcnt = 0;
    logic [31:0] last_f = '0, last_d = '0;
    vec_t        vecs[6];
    vec_t        v;

    function automatic txn_t mk(logic is_d, logic we, logic [3:0] be, logic [31:0] addr,
                                logic [31:0] wdata, logic [31:0] rdata, logic tmo);
        txn_t t;
        t.is_d = is_d; t.we = we; t.be = be; t.addr = addr;
        t.wdata = wdata; t.rdata = rdata; t.tmo = tmo;
        return t;
    endfunction

    task automatic check(string name, logic [63:0] act, logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic drive();
        f_req = f_q.size() != 0;
        d_req = d_q.size() != 0;
        if (f_req) f_addr = f_q[0].addr;
        if (d_req) begin
            d_we = d_q[0].we; d_be = d_q[0].be; d_addr = d_q[0].addr; d_wdata = d_q[0].wdata;
        end
    endtask

    // Memory: raises mem_ready lat cycles after mem_req first appears, holds it until mem_req drops.
    always @(negedge clk) begin
        if (!mem_req) begin
            mcnt = 0;
            mem_ready = 1'b0;
        end else if (!mem_ready) begin
            mcnt++;
            if (mcnt == lat + 1) begin
                if (exp_q.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL unexpected_mem_access actual addr=%0h required none", mem_addr);
                end else begin
                    check("mem_we", mem_we, exp_q[0].we);
                    check("mem_be", mem_be, exp_q[0].be);
                    check("mem_addr", mem_addr, exp_q[0].addr);
                    if (exp_q[0].we) check("mem_wdata", mem_wdata, exp_q[0].wdata);
                    mem_rdata = exp_q[0].rdata;
                end
                mem_ready = 1'b1;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        if (f_ack || d_ack) begin
            if (exp_q.size() == 0) begin
                checks++; failures++;
                $display("FAIL spurious_ack actual f_ack=%b d_ack=%b required none", f_ack, d_ack);
            end else begin
                txn_t e;
                e = exp_q.pop_front();
                check("ack_port", {f_ack, d_ack}, e.is_d ? 2'b01 : 2'b10);
                check("rdata", e.is_d ? d_rdata : f_rdata, e.rdata);
                check("hold_other_rdata", e.is_d ? f_rdata : d_rdata, e.is_d ? last_f : last_d);
                check("err", err, e.tmo);
                if (e.is_d) last_d = e.rdata; else last_f = e.rdata;
            end
            if (f_ack && f_q.size() != 0) void'(f_q.pop_front());
            if (d_ack && d_q.size() != 0) void'(d_q.pop_front());
        end
        drive();
    endtask

    task automatic run_idle(int budget);
        int n = 0;
        while ((exp_q.size() != 0 || f_q.size() != 0 || d_q.size() != 0) && n < budget) begin
            step();
            n++;
        end
        checks++;
        if (exp_q.size() != 0 || f_q.size() != 0 || d_q.size() != 0) begin
            failures++;
            $display("FAIL completion_timeout actual pending=%0d required 0", exp_q.size());
            exp_q.delete(); f_q.delete(); d_q.delete();
            drive();
        end
    endtask

    initial begin
        vecs[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 4'hF, 32'h0000_0040, 32'h0, 32'h0, 32'h2001_0005, 32'h0, 2};
        vecs[1] = '{1'b1, 1'b1, 1'b1, 1'b1, 4'b0011, 4'b0011, 32'h0000_0044, 32'h0000_0100, 32'hDEAD_BEEF, 32'h1111_2222, 32'h0BAD_0001, 1};
        vecs[2] = '{1'b0, 1'b1, 1'b0, 1'b1, 4'b0101, 4'hF, 32'h0, 32'h0000_0200, 32'h0, 32'h0, 32'hCAFE_F00D, 0};
        vecs[3] = '{1'b1, 1'b1, 1'b0, 1'b1, 4'b1000, 4'hF, 32'h0000_0048, 32'h0000_0204, 32'h0, 32'h8765_4321, 32'h1234_5678, 3};
        vecs[4] = '{1'b0, 1'b1, 1'b1, 1'b1, 4'b1100, 4'b1100, 32'h0, 32'h0000_0208, 32'h5555_AAAA, 32'h0, 32'h0000_0000, 1};
        vecs[5] = '{1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 4'hF, 32'h0000_004C, 32'h0, 32'h0, 32'hFFFF_FFFF, 32'h0, 0};

        repeat (3) step();
        check("rst_acks", {f_ack, d_ack, err}, 3'b000);
        check("rst_mem_req_we", {mem_req, mem_we}, 2'b00);
        check("rst_mem_be", mem_be, 4'h0);
        check("rst_mem_addr", mem_addr, 32'h0);
        check("rst_mem_wdata", mem_wdata, 32'h0);
        check("rst_rdata", {f_rdata, d_rdata}, 64'h0);
        rst = 1'b0;
        step();

        for (int i = 0; i < 6; i++) begin
            v = vecs[i];
            lat = v.lat;
            if (v.d_on) d_q.push_back(mk(1'b1, v.d_we, v.d_be, v.d_addr, v.d_wdata, 32'h0, 1'b0));
            if (v.f_on) f_q.push_back(mk(1'b0, 1'b0, 4'hF, v.f_addr, 32'h0, 32'h0, 1'b0));
            if (v.d_on && v.d_first) exp_q.push_back(mk(1'b1, v.d_we, v.exp_be, v.d_addr, v.d_wdata, v.d_rd, 1'b0));
            if (v.f_on) exp_q.push_back(mk(1'b0, 1'b0, 4'hF, v.f_addr, 32'h0, v.f_rd, 1'b0));
            if (v.d_on && !v.d_first) exp_q.push_back(mk(1'b1, v.d_we, v.exp_be, v.d_addr, v.d_wdata, v.d_rd, 1'b0));
            drive();
            run_idle(60);
        end

        // Exact latency: req in IDLE cycle t, mem_req t+1, ready t+3, ack t+4 only.
        step();
        lat = 2;
        f_q.push_back(mk(1'b0, 1'b0, 4'hF, 32'h0000_0040, 32'h0, 32'h0, 1'b0));
        exp_q.push_back(mk(1'b0, 1'b0, 4'hF, 32'h0000_0040, 32'h0, 32'h2001_0005, 1'b0));
        drive();
        for (int i = 1; i <= 5; i++) begin
            step();
            check($sformatf("lat_f_ack_c%0d", i), f_ack, i == 4);
            check($sformatf("lat_mem_req_c%0d", i), mem_req, i < 4);
        end

        // Starvation: four D grants over a waiting F, then F, then remaining D.
        lat = 0;
        for (int i = 0; i < 6; i++)
            d_q.push_back(mk(1'b1, 1'b0, 4'h0, 32'h300 + 32'(i * 4), 32'h0, 32'h0, 1'b0));
        f_q.push_back(mk(1'b0, 1'b0, 4'hF, 32'h0000_0400, 32'h0, 32'h0, 1'b0));
        for (int i = 0; i < 4; i++)
            exp_q.push_back(mk(1'b1, 1'b0, 4'hF, 32'h300 + 32'(i * 4), 32'h0, 32'h5000 + 32'(i), 1'b0));
        exp_q.push_back(mk(1'b0, 1'b0, 4'hF, 32'h0000_0400, 32'h0, 32'h6000_0000, 1'b0));
        for (int i = 4; i < 6; i++)
            exp_q.push_back(mk(1'b1, 1'b0, 4'hF, 32'h300 + 32'(i * 4), 32'h0, 32'h5000 + 32'(i), 1'b0));
        drive();
        run_idle(100);

        // Starve count cleared: a simultaneous pair goes D first again.
        d_q.push_back(mk(1'b1, 1'b0, 4'h0, 32'h0000_0500, 32'h0, 32'h0, 1'b0));
        f_q.push_back(mk(1'b0, 1'b0, 4'hF, 32'h0000_0504, 32'h0, 32'h0, 1'b0));
        exp_q.push_back(mk(1'b1, 1'b0, 4'hF, 32'h0000_0500, 32'h0, 32'hA5A5_0001, 1'b0));
        exp_q.push_back(mk(1'b0, 1'b0, 4'hF, 32'h0000_0504, 32'h0, 32'hA5A5_0002, 1'b0));
        drive();
        run_idle(40);

        // Reset while BUSY: access abandoned, no ack, next request served normally.
        step();
        lat = 10;
        f_q.push_back(mk(1'b0, 1'b0, 4'hF, 32'h0000_0080, 32'h0, 32'h0, 1'b0));
        drive();
        step();
        check("rst_busy_mem_req_before", mem_req, 1'b1);
        rst = 1'b1;
        f_q.delete();
        drive();
        step();
        check("rst_busy_mem_req_after", mem_req, 1'b0);
        check("rst_busy_no_ack", {f_ack, d_ack}, 2'b00);
        check("rst_busy_mem_addr", mem_addr, 32'h0);
        rst = 1'b0;
        last_f = '0;
        last_d = '0;
        step();
        lat = 1;
        f_q.push_back(mk(1'b0, 1'b0, 4'hF, 32'h0000_0084, 32'h0, 32'h0, 1'b0));
        exp_q.push_back(mk(1'b0, 1'b0, 4'hF, 32'h0000_0084, 32'h0, 32'h4242_4242, 1'b0));
        drive();
        run_idle(40);

        // clk_en low for 3 cycles in BUSY with mem_ready already high.
        step();
        lat = 0;
        f_q.push_back(mk(1'b0, 1'b0, 4'hF, 32'h0000_00C0, 32'h0, 32'h0, 1'b0));
        exp_q.push_back(mk(1'b0, 1'b0, 4'hF, 32'h0000_00C0, 32'h0, 32'h7777_0000, 1'b0));
        drive();
        step();
        clk_en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check($sformatf("frozen_c%0d", i), {mem_req, f_ack, mem_ready}, 3'b101);
        end
        clk_en = 1'b1;
        step();
        check("thaw_f_ack", f_ack, 1'b1);
        step();
        check("thaw_f_ack_once", f_ack, 1'b0);
        check("thaw_drained", exp_q.size(), 0);

`ifdef MEM_TIMEOUT_EN
        step();
        lat = 1000;
        d_q.push_back(mk(1'b1, 1'b0, 4'h0, 32'h0000_0600, 32'h0, 32'h0, 1'b0));
        exp_q.push_back(mk(1'b1, 1'b0, 4'hF, 32'h0000_0600, 32'h0, 32'h0, 1'b1));
        drive();
        run_idle(40);
        step();
        check("timeout_err_cleared", err, 1'b0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
